fixedpoint_to_cartesian_arbiter: RTL and testbench
==================================================

Name: fixedpoint_to_cartesian_arbiter

Overview:
Shares one spherical-to-cartesian converter (84-cycle latency, in-order results) between N requesters, such as per-ray marching lanes.
- Arbitrates requests round-robin under a credit limit.
- Tags each issued request with its requester index in an in-order tag FIFO.
- Routes each converter result back to the requester that issued it.
- Sits between the ray-lane array and the single converter instance.

Parameters:
N_REQ, 4, number of requesters (2..16)
MAX_INFLIGHT, 96, credit limit and tag FIFO depth; must be at least converter latency + 2
CNV_LATENCY, 84, converter latency in cycles; sets the post-reset drain window
IDX_W, $clog2(N_REQ), requester index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept, at most one bit high
req_theta  in  N_REQ x fixedpoint::number  polar angle
req_phi  in  N_REQ x fixedpoint::number  azimuth
req_r  in  N_REQ x fixedpoint::number  radius
cnv_in_valid  out  1  issue strobe to converter
cnv_theta/cnv_phi/cnv_r  out  fixedpoint::number each  converter operands
cnv_out_valid  in  1  converter result strobe
cnv_x/cnv_y/cnv_z  in  fixedpoint::number each  converter results
rsp_valid  out  N_REQ  one-hot result strobe
rsp_x/rsp_y/rsp_z  out  fixedpoint::number each  result, broadcast to all requesters
inflight  out  $clog2(MAX_INFLIGHT+1)  outstanding request count
err_orphan  out  1  sticky error: result arrived with no tag

Behaviour:
- Reset (asynchronous, rst_n low): clear all outputs to 0, round-robin pointer to 0, credits to MAX_INFLIGHT, tag FIFO empty, drain counter to CNV_LATENCY+2, err_orphan to 0.
- Arbitration (combinational):
  - Search starts at the pointer.
  - The first i with req_valid[i] gets req_ready[i]=1, only if credits>0 and the drain counter is 0.
  - A transfer occurs when req_valid[i] and req_ready[i] are both high.
  - On a transfer, the pointer moves to (i+1) mod N_REQ; otherwise it holds.
- Issue stage: registered, 1 cycle.
  - On a transfer: cnv_in_valid=1, operands are the granted requester's operands, and the index i is pushed to the tag FIFO.
  - Without a transfer: cnv_in_valid=0 and operands hold their last value.
- Credits: issue decrements; a result pop increments; both in the same cycle leave credits unchanged. inflight = MAX_INFLIGHT - credits.
- Return path:
  - On cnv_out_valid with the FIFO non-empty: pop tag t.
  - Next cycle: rsp_valid = one-hot(t), and rsp_x/y/z = registered cnv_x/y/z.
  - Total request-to-response latency = 1 + CNV_LATENCY + 1 = 86 cycles.
  - Requesters must accept results; the return path has no backpressure.
- Orphan result: cnv_out_valid with the FIFO empty and the drain counter at 0 sets err_orphan. The result is dropped, rsp_valid stays 0, and err_orphan clears only on reset.
- Drain window: after reset the drain counter decrements each cycle. While it is nonzero, grants are blocked and cnv_out_valid is ignored silently. This flushes stale converter results from before a mid-operation reset.
- Tag FIFO: circular buffer with a separate full flag.
  - Wrap-around at MAX_INFLIGHT.
  - Push and pop in the same cycle are allowed, including when full (pop first frees the slot).
  - The credit limit makes push-when-full unreachable.
- Fairness: with all N_REQ requesting continuously, grants rotate 0,1,..,N_REQ-1, one per cycle.

Optional Feature:
FIXEDPOINT_ARB_STATS_EN
- Defined: adds output ports grant_cnt[N_REQ] and stall_cnt, 32 bits each, cleared on reset, saturating at all-ones.
  - grant_cnt[i] increments on each transfer from requester i.
  - stall_cnt increments on each cycle where some req_valid is high but no grant is given (credits exhausted or draining).
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fixedpoint (existing) supplies fixedpoint::number.
- Add to package fixedpoint: the constant CART_LATENCY = 84 (default for CNV_LATENCY) and a struct sph_req_t {theta, phi, r}.
- One sub-module: arb_tag_fifo, a parameterised circular FIFO (WIDTH, DEPTH) exposing push, pop, full, empty and dout.

Test Plan:
1. Wait out the drain window, then requester 2 sends theta=0, phi=0, r=1.0 -> cnv_in_valid 1 cycle later; with a behavioural 84-cycle converter model, rsp_valid=4'b0100 at cycle 86 with x=0, y=0, z=1.0.
2. All 4 request continuously for 20 cycles -> grant order 0,1,2,3 repeating; rsp_valid order identical; inflight peaks at 20.
3. MAX_INFLIGHT=8 with the converter stalled (no cnv_out_valid) -> exactly 8 grants, then req_ready=0 and inflight=8; one result pop with a request pending -> exactly one new grant the following cycle.
4. Inject cnv_out_valid with no outstanding issue, after the drain window -> err_orphan=1 (sticky), no rsp_valid.
5. Assert rst_n with 10 requests in flight, then replay their results within CNV_LATENCY+2 cycles -> no rsp_valid, err_orphan=0, req_ready=0 until the drain completes.
6. With FIXEDPOINT_ARB_STATS_EN, run scenario 3 -> grant_cnt sum=9; stall_cnt equals the number of blocked cycles that had a request pending.

Source files
------------

// File: rtl/fixedpoint_to_cartesian_arbiter_pkg.sv
// fixedpoint: Q16.16 number type, converter latency constant and spherical request bundle
package fixedpoint;
   typedef logic signed [31:0] number;
   localparam int CART_LATENCY = 84;
   typedef struct packed {
      number theta;
      number phi;
      number r;
   } sph_req_t;
endpackage

// File: rtl/fixedpoint_to_cartesian_arbiter_tag_fifo.sv
// arb_tag_fifo: circular FIFO with separate full flag; a pop frees its slot for a same-cycle push
module arb_tag_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 96
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic full_q, full_d, do_push, do_pop;
   logic [WIDTH-1:0] mem_q [DEPTH];
   assign empty = (wr_q == rd_q) && !full_q;
   assign full  = full_q;
   assign dout  = mem_q[rd_q];
   always_comb begin
      do_pop  = pop && !empty;
      do_push = push && (!full_q || do_pop);
      wr_d    = do_push ? (wr_q == AW'(DEPTH-1) ? '0 : wr_q + 1'b1) : wr_q;
      rd_d    = do_pop ? (rd_q == AW'(DEPTH-1) ? '0 : rd_q + 1'b1) : rd_q;
      full_d  = (do_push && !do_pop) ? (wr_d == rd_q) : ((do_pop && !do_push) ? 1'b0 : full_q);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_q   <= '0;
         rd_q   <= '0;
         full_q <= 1'b0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         full_q <= full_d;
      end
   always_ff @(posedge clk)
      if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/fixedpoint_to_cartesian_arbiter.sv
// fixedpoint_to_cartesian_arbiter: round-robin, credit-limited sharing of one spherical-to-cartesian converter.
// Define FIXEDPOINT_ARB_STATS_EN to add saturating grant_cnt/stall_cnt counters.
module fixedpoint_to_cartesian_arbiter
   import fixedpoint::*;
#(
   parameter int N_REQ        = 4,
   parameter int MAX_INFLIGHT = 96,
   parameter int CNV_LATENCY  = CART_LATENCY,
   parameter int IDX_W        = $clog2(N_REQ)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [N_REQ-1:0]                  req_valid,
   output logic [N_REQ-1:0]                  req_ready,
   input  number [N_REQ-1:0]                 req_theta,
   input  number [N_REQ-1:0]                 req_phi,
   input  number [N_REQ-1:0]                 req_r,
   output logic                              cnv_in_valid,
   output number                             cnv_theta,
   output number                             cnv_phi,
   output number                             cnv_r,
   input  logic                              cnv_out_valid,
   input  number                             cnv_x,
   input  number                             cnv_y,
   input  number                             cnv_z,
   output logic [N_REQ-1:0]                  rsp_valid,
   output number                             rsp_x,
   output number                             rsp_y,
   output number                             rsp_z,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
   output logic                              err_orphan
`ifdef FIXEDPOINT_ARB_STATS_EN
   ,
   output logic [N_REQ-1:0][31:0]            grant_cnt,
   output logic [31:0]                       stall_cnt
`endif
);
   localparam int CW = $clog2(MAX_INFLIGHT+1);
   localparam int DW = $clog2(CNV_LATENCY+3);
   logic [IDX_W-1:0] ptr_q, ptr_d, gnt_idx, tag;
   logic [CW-1:0] credits_q, credits_d;
   logic [DW-1:0] drain_q, drain_d;
   sph_req_t op_q, op_d;
   logic cnv_in_valid_q, cnv_in_valid_d, err_q, err_d;
   logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
   number rsp_x_q, rsp_x_d, rsp_y_q, rsp_y_d, rsp_z_q, rsp_z_d;
   logic found, can, xfer, pop, fifo_full, fifo_empty;

   arb_tag_fifo #(.WIDTH(IDX_W), .DEPTH(MAX_INFLIGHT)) u_tag_fifo (
      .clk(clk), .rst_n(rst_n), .push(xfer), .pop(pop), .din(gnt_idx),
      .dout(tag), .full(fifo_full), .empty(fifo_empty)
   );

   always_comb begin
      int j;
      j       = 0;
      found   = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         j = int'(ptr_q) + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (!found && req_valid[j]) begin
            found   = 1'b1;
            gnt_idx = IDX_W'(j);
         end
      end
      can            = credits_q != '0 && drain_q == '0 && !fifo_full;
      xfer           = found && can;
      req_ready      = xfer ? N_REQ'(1) << gnt_idx : '0;
      // results during the drain window belong to the pre-reset session and are dropped silently
      pop            = cnv_out_valid && drain_q == '0 && !fifo_empty;
      err_d          = err_q || (cnv_out_valid && drain_q == '0 && fifo_empty);
      ptr_d          = xfer ? (gnt_idx == IDX_W'(N_REQ-1) ? '0 : gnt_idx + 1'b1) : ptr_q;
      credits_d      = credits_q - CW'(xfer) + CW'(pop);
      drain_d        = drain_q == '0 ? drain_q : drain_q - 1'b1;
      cnv_in_valid_d = xfer;
      op_d           = xfer ? sph_req_t'{req_theta[gnt_idx], req_phi[gnt_idx], req_r[gnt_idx]} : op_q;
      rsp_valid_d    = pop ? N_REQ'(1) << tag : '0;
      rsp_x_d        = pop ? cnv_x : rsp_x_q;
      rsp_y_d        = pop ? cnv_y : rsp_y_q;
      rsp_z_d        = pop ? cnv_z : rsp_z_q;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ptr_q          <= '0;
         credits_q      <= CW'(MAX_INFLIGHT);
         drain_q        <= DW'(CNV_LATENCY+2);
         op_q           <= '0;
         cnv_in_valid_q <= 1'b0;
         rsp_valid_q    <= '0;
         rsp_x_q        <= '0;
         rsp_y_q        <= '0;
         rsp_z_q        <= '0;
         err_q          <= 1'b0;
      end else begin
         ptr_q          <= ptr_d;
         credits_q      <= credits_d;
         drain_q        <= drain_d;
         op_q           <= op_d;
         cnv_in_valid_q <= cnv_in_valid_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_x_q        <= rsp_x_d;
         rsp_y_q        <= rsp_y_d;
         rsp_z_q        <= rsp_z_d;
         err_q          <= err_d;
      end

   assign cnv_in_valid = cnv_in_valid_q;
   assign cnv_theta    = op_q.theta;
   assign cnv_phi      = op_q.phi;
   assign cnv_r        = op_q.r;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_x        = rsp_x_q;
   assign rsp_y        = rsp_y_q;
   assign rsp_z        = rsp_z_q;
   assign inflight     = CW'(MAX_INFLIGHT) - credits_q;
   assign err_orphan   = err_q;

`ifdef FIXEDPOINT_ARB_STATS_EN
   logic [N_REQ-1:0][31:0] grant_cnt_q, grant_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;
   always_comb begin
      grant_cnt_d = grant_cnt_q;
      for (int i = 0; i < N_REQ; i++)
         if (req_ready[i] && grant_cnt_q[i] != '1) grant_cnt_d[i] = grant_cnt_q[i] + 1'b1;
      stall_cnt_d = (found && !can && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         grant_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         grant_cnt_q <= grant_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   assign grant_cnt = grant_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fixedpoint_to_cartesian_arbiter.sv
// tb_fixedpoint_to_cartesian_arbiter: directed checks of arbitration, return routing, credits, orphans and drain.
module tb_fixedpoint_to_cartesian_arbiter;
   import fixedpoint::*;
   localparam int N = 4;
   localparam int LAT = CART_LATENCY;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   int vectors = 0;
   int miscompares = 0;
   int exp_ptr = 0;

   logic [N-1:0] req_valid, req_ready, rsp_valid;
   number [N-1:0] req_theta, req_phi, req_r;
   logic cnv_in_valid, cnv_out_valid, err_orphan;
   number cnv_theta, cnv_phi, cnv_r, cnv_x, cnv_y, cnv_z, rsp_x, rsp_y, rsp_z;
   logic [6:0] inflight;
   logic inj_v;
   number inj_x, inj_y, inj_z;

   logic [N-1:0] req_valid8, req_ready8, rsp_valid8;
   logic cnv_in_valid8, cnv_out_valid8, err_orphan8;
   number cnv_theta8, cnv_phi8, cnv_r8, cnv_x8, rsp_x8, rsp_y8, rsp_z8;
   logic [3:0] inflight8;
`ifdef FIXEDPOINT_ARB_STATS_EN
   logic [N-1:0][31:0] grant_cnt, grant_cnt8;
   logic [31:0] stall_cnt, stall_cnt8;
`endif

   // stand-in converter: fixed latency, result carries the request operands (x=theta, y=phi, z=r)
   logic [LAT-1:0] pv = '0;
   number px [LAT];
   number py [LAT];
   number pz [LAT];
   always @(posedge clk) begin
      pv    <= {pv[LAT-2:0], cnv_in_valid};
      px[0] <= cnv_theta;
      py[0] <= cnv_phi;
      pz[0] <= cnv_r;
      for (int k = 1; k < LAT; k++) begin
         px[k] <= px[k-1];
         py[k] <= py[k-1];
         pz[k] <= pz[k-1];
      end
   end
   assign cnv_out_valid = pv[LAT-1] | inj_v;
   assign cnv_x = inj_v ? inj_x : px[LAT-1];
   assign cnv_y = inj_v ? inj_y : py[LAT-1];
   assign cnv_z = inj_v ? inj_z : pz[LAT-1];

   fixedpoint_to_cartesian_arbiter #(.N_REQ(N)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_theta(req_theta), .req_phi(req_phi), .req_r(req_r),
      .cnv_in_valid(cnv_in_valid), .cnv_theta(cnv_theta), .cnv_phi(cnv_phi), .cnv_r(cnv_r),
      .cnv_out_valid(cnv_out_valid), .cnv_x(cnv_x), .cnv_y(cnv_y), .cnv_z(cnv_z),
      .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
      .inflight(inflight), .err_orphan(err_orphan)
`ifdef FIXEDPOINT_ARB_STATS_EN
      , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
   );

   fixedpoint_to_cartesian_arbiter #(.N_REQ(N), .MAX_INFLIGHT(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid8), .req_ready(req_ready8),
      .req_theta(req_theta), .req_phi(req_phi), .req_r(req_r),
      .cnv_in_valid(cnv_in_valid8), .cnv_theta(cnv_theta8), .cnv_phi(cnv_phi8), .cnv_r(cnv_r8),
      .cnv_out_valid(cnv_out_valid8), .cnv_x(cnv_x8), .cnv_y(cnv_x8), .cnv_z(cnv_x8),
      .rsp_valid(rsp_valid8), .rsp_x(rsp_x8), .rsp_y(rsp_y8), .rsp_z(rsp_z8),
      .inflight(inflight8), .err_orphan(err_orphan8)
`ifdef FIXEDPOINT_ARB_STATS_EN
      , .grant_cnt(grant_cnt8), .stall_cnt(stall_cnt8)
`endif
   );

   task automatic test_reset();
      int ready_at;
      ready_at = 0;
      req_valid = '1;
      repeat (3) @(negedge clk);
      #1;
      vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
      vectors++; if (cnv_in_valid !== 1'b0 || cnv_theta !== 32'h0) begin miscompares++; $display("FAIL reset_issue: got %b/%h expected 0/0", cnv_in_valid, cnv_theta); end
      vectors++; if (rsp_valid !== 4'b0000 || err_orphan !== 1'b0) begin miscompares++; $display("FAIL reset_rsp: got %b/%b expected 0000/0", rsp_valid, err_orphan); end
      vectors++; if (inflight !== 7'd0 || inflight8 !== 4'd0) begin miscompares++; $display("FAIL reset_inflight: got %0d/%0d expected 0/0", inflight, inflight8); end
      rst_n = 1'b1;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk); #1;
         if (req_ready !== 4'b0000) begin ready_at = k; break; end
      end
      req_valid = '0;
      vectors++; if (ready_at != LAT + 2) begin miscompares++; $display("FAIL drain_length: got %0d expected %0d", ready_at, LAT + 2); end
      vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL first_grant: got %b expected 0001", req_ready); end
   endtask

   task automatic test_single();
      int lat;
      lat = 0;
      @(negedge clk);
      req_valid = 4'b0100; req_theta[2] = 32'h0; req_phi[2] = 32'h0; req_r[2] = 32'h0001_0000;
      #1;
      vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
      @(negedge clk); req_valid = '0; #1;
      vectors++; if (cnv_in_valid !== 1'b1 || cnv_r !== 32'h0001_0000 || cnv_theta !== 32'h0) begin miscompares++; $display("FAIL single_issue: got %b r=%h expected 1 r=00010000", cnv_in_valid, cnv_r); end
      vectors++; if (inflight !== 7'd1) begin miscompares++; $display("FAIL single_inflight: got %0d expected 1", inflight); end
      for (int k = 2; k <= 200; k++) begin
         @(negedge clk); #1;
         if (rsp_valid !== 4'b0000) begin lat = k; break; end
      end
      vectors++; if (lat != 86) begin miscompares++; $display("FAIL single_latency: got %0d expected 86", lat); end
      vectors++; if (rsp_valid !== 4'b0100) begin miscompares++; $display("FAIL single_route: got %b expected 0100", rsp_valid); end
      vectors++; if (rsp_x !== 32'h0 || rsp_y !== 32'h0 || rsp_z !== 32'h0001_0000) begin miscompares++; $display("FAIL single_data: got %h %h %h expected 0 0 00010000", rsp_x, rsp_y, rsp_z); end
      @(negedge clk); #1;
      vectors++; if (rsp_valid !== 4'b0000 || inflight !== 7'd0) begin miscompares++; $display("FAIL single_done: got %b/%0d expected 0000/0", rsp_valid, inflight); end
      exp_ptr = 3;
   endtask

   task automatic test_fairness();
      int q[$];
      int e, got;
      got = 0;
      for (int i = 0; i < N; i++) begin
         req_theta[i] = 32'h1000 * (i + 1);
         req_phi[i]   = 32'h20 + i;
         req_r[i]     = 32'h0003_0000;
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); req_valid = '1; #1;
         vectors++; if (req_ready !== 4'(1 << exp_ptr)) begin miscompares++; $display("FAIL rr_grant%0d: got %b expected %b", c, req_ready, 4'(1 << exp_ptr)); end
         q.push_back(exp_ptr);
         exp_ptr = (exp_ptr + 1) % N;
      end
      @(negedge clk); req_valid = '0; #1;
      vectors++; if (inflight !== 7'd20) begin miscompares++; $display("FAIL rr_inflight_peak: got %0d expected 20", inflight); end
      for (int k = 0; k < 300 && got < 20; k++) begin
         @(negedge clk); #1;
         if (rsp_valid !== 4'b0000) begin
            e = q.pop_front();
            got++;
            vectors++; if (rsp_valid !== 4'(1 << e) || rsp_x !== number'(32'h1000 * (e + 1))) begin miscompares++; $display("FAIL rr_rsp%0d: got %b x=%h expected %b x=%h", got, rsp_valid, rsp_x, 4'(1 << e), 32'h1000 * (e + 1)); end
         end
      end
      vectors++; if (got != 20) begin miscompares++; $display("FAIL rr_rsp_count: got %0d expected 20", got); end
      @(negedge clk); #1;
      vectors++; if (inflight !== 7'd0) begin miscompares++; $display("FAIL rr_inflight_end: got %0d expected 0", inflight); end
   endtask

   task automatic test_orphan();
      int bad;
      bad = 0;
      @(negedge clk); inj_v = 1'b1; inj_x = 32'hDEAD; inj_y = 32'hBEEF; inj_z = 32'h1234; #1;
      vectors++; if (err_orphan !== 1'b0) begin miscompares++; $display("FAIL orphan_pre: got %b expected 0", err_orphan); end
      @(negedge clk); inj_v = 1'b0; #1;
      vectors++; if (err_orphan !== 1'b1 || rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL orphan_set: got %b/%b expected 1/0000", err_orphan, rsp_valid); end
      repeat (5) begin
         @(negedge clk); #1;
         if (err_orphan !== 1'b1 || rsp_valid !== 4'b0000) bad++;
      end
      vectors++; if (bad != 0) begin miscompares++; $display("FAIL orphan_sticky: got %0d bad cycles expected 0", bad); end
      vectors++; if (inflight !== 7'd0) begin miscompares++; $display("FAIL orphan_inflight: got %0d expected 0", inflight); end
   endtask

   task automatic test_drain();
      int rsp_bad, err_bad, rdy_bad, stale;
      rsp_bad = 0; err_bad = 0; rdy_bad = 0; stale = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); req_valid = '1;
      end
      @(negedge clk); req_valid = '0; #1;
      vectors++; if (inflight !== 7'd10) begin miscompares++; $display("FAIL drain_inflight: got %0d expected 10", inflight); end
      repeat (5) @(negedge clk);
      rst_n = 1'b0; req_valid = '1; #1;
      vectors++; if (inflight !== 7'd0 || err_orphan !== 1'b0 || rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL async_reset: got %0d/%b/%b expected 0/0/0000", inflight, err_orphan, rsp_valid); end
      @(negedge clk); rst_n = 1'b1;
      for (int k = 1; k <= LAT + 2; k++) begin
         @(negedge clk); #1;
         if (rsp_valid !== 4'b0000) rsp_bad++;
         if (err_orphan !== 1'b0) err_bad++;
         if (cnv_out_valid) stale++;
         if (k < LAT + 2 && req_ready !== 4'b0000) rdy_bad++;
      end
      vectors++; if (stale != 10) begin miscompares++; $display("FAIL drain_stale: got %0d expected 10", stale); end
      vectors++; if (rsp_bad != 0 || err_bad != 0) begin miscompares++; $display("FAIL drain_quiet: got %0d rsp/%0d err expected 0/0", rsp_bad, err_bad); end
      vectors++; if (rdy_bad != 0) begin miscompares++; $display("FAIL drain_block: got %0d ready cycles expected 0", rdy_bad); end
      vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL drain_release: got %b expected 0001", req_ready); end
      req_valid = '0;
   endtask

   task automatic test_credit();
      for (int i = 0; i < 12; i++) begin
         @(negedge clk); req_valid8 = '1; #1;
         vectors++; if (req_ready8 !== (i < 8 ? 4'(1 << (i % 4)) : 4'b0000)) begin miscompares++; $display("FAIL credit_grant%0d: got %b expected %b", i, req_ready8, i < 8 ? 4'(1 << (i % 4)) : 4'b0000); end
      end
      @(negedge clk); cnv_out_valid8 = 1'b1; cnv_x8 = 32'h0ABC_0001; #1;
      vectors++; if (req_ready8 !== 4'b0000 || inflight8 !== 4'd8) begin miscompares++; $display("FAIL credit_full: got %b/%0d expected 0000/8", req_ready8, inflight8); end
      @(negedge clk); cnv_out_valid8 = 1'b0; #1;
      vectors++; if (req_ready8 !== 4'b0001 || inflight8 !== 4'd7) begin miscompares++; $display("FAIL credit_return: got %b/%0d expected 0001/7", req_ready8, inflight8); end
      vectors++; if (rsp_valid8 !== 4'b0001 || rsp_x8 !== 32'h0ABC_0001) begin miscompares++; $display("FAIL credit_rsp: got %b x=%h expected 0001 x=0abc0001", rsp_valid8, rsp_x8); end
      @(negedge clk); #1;
      vectors++; if (req_ready8 !== 4'b0000 || inflight8 !== 4'd8) begin miscompares++; $display("FAIL credit_one_grant: got %b/%0d expected 0000/8", req_ready8, inflight8); end
      req_valid8 = '0;
      @(negedge clk); #1;
      vectors++; if (rsp_valid8 !== 4'b0000 || err_orphan8 !== 1'b0) begin miscompares++; $display("FAIL credit_quiet: got %b/%b expected 0000/0", rsp_valid8, err_orphan8); end
`ifdef FIXEDPOINT_ARB_STATS_EN
      vectors++; if (grant_cnt8[0] !== 32'd3 || grant_cnt8[1] !== 32'd2 || grant_cnt8[2] !== 32'd2 || grant_cnt8[3] !== 32'd2) begin miscompares++; $display("FAIL stats_grant: got %0d %0d %0d %0d expected 3 2 2 2", grant_cnt8[0], grant_cnt8[1], grant_cnt8[2], grant_cnt8[3]); end
      vectors++; if (stall_cnt8 !== 32'd5) begin miscompares++; $display("FAIL stats_stall: got %0d expected 5", stall_cnt8); end
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      req_valid = '0; req_valid8 = '0;
      req_theta = '0; req_phi = '0; req_r = '0;
      inj_v = 1'b0; inj_x = '0; inj_y = '0; inj_z = '0;
      cnv_out_valid8 = 1'b0; cnv_x8 = '0;
      test_reset();
      test_single();
      test_fairness();
      test_orphan();
      test_drain();
      test_credit();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
